alarm_scheduler: RTL and testbench

//  Sequences the per-day alarm register bank against current time and owns the alarm life cycle:

---
 rtl/alarm_pkg.sv | 42 ++++
 rtl/alarm_scheduler_min_countdown.sv | 38 +++
 rtl/alarm_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
//  Shared definitions for the alarm scheduler:
//   - state_t        : scheduler life-cycle states
//   - DEF_*          : default parameter values for alarm_scheduler
//   - DAY_W          : width of the day code / slot index
//   - SNZ_LEFT_W     : width of the remaining-snooze counter
//   - slot_en_bit()  : position of the enable bit inside an alarm slot word
//   - count_width()  : width needed for a minute countdown holding max(a,b)
//  Alarm slot layout: [TW] = enable, [TW-1:0] = alarm time word.
// ---------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  localparam int DEF_TW           = 12;
  localparam int DEF_NSLOT        = 7;
  localparam int DEF_SNOOZE_MIN   = 9;
  localparam int DEF_RING_MAX_MIN = 10;
  localparam int DEF_MAX_SNOOZE   = 3;

  localparam int DAY_W      = 3;
  localparam int SNZ_LEFT_W = 2;

  // Enable bit sits directly above the time field.
  function automatic int slot_en_bit(input int tw);
    return tw;
  endfunction

  // Bits needed to hold the larger of two minute counts.
  function automatic int count_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarm_scheduler_min_countdown.sv
// ---------------------------------------------------------------------------
// min_countdown
//  Minute countdown register: load a start value, decrement by one on each
//  accepted tick, saturate at zero.
//  Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val (has priority over dec)
//   load_val  in   W  start value
//   dec       in   decrement request (ignored when already zero)
//   count     out  W  current count
//   zero      out  count == 0
// ---------------------------------------------------------------------------
module min_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_scheduler.sv
// ---------------------------------------------------------------------------
// alarm_scheduler
//  Owns the alarm life cycle: on each minute tick it reads today's alarm slot,
//  compares it with the current time and, on a hit, rings the buzzer. While
//  ringing the user may snooze (limited number of times) or stop; unattended
//  ringing stops by itself after RING_MAX_MIN minutes.
//  Ports:
//   Clk        in   system clock, rising edge
//   Clr        in   asynchronous active-low reset
//   min_tick   in   1-cycle pulse per minute
//   cur_day    in   3     current day code
//   cur_time   in   TW    current time word
//   edit_busy  in   registers being edited; defers the scheduled fetch
//   slot_data  in   TW+1  alarm slot, valid the cycle after slot_rd
//   Snooze     in   snooze button level
//   Stop       in   stop button level
//   Mute       in   silences Sound only
//   slot_sel   out  3     slot index to read
//   slot_rd    out  1-cycle read strobe
//   Sound      out  buzzer enable
//   ringing    out  state is RING
//   snoozed    out  state is SNOOZE
//   alarm_evt  out  1-cycle pulse on every entry to RING
//   snz_left   out  2     snoozes remaining for this alarm event
// ---------------------------------------------------------------------------
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int TW           = DEF_TW,
  parameter int NSLOT        = DEF_NSLOT,
  parameter int SNOOZE_MIN   = DEF_SNOOZE_MIN,
  parameter int RING_MAX_MIN = DEF_RING_MAX_MIN,
  parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  min_tick,
  input  logic [DAY_W-1:0]      cur_day,
  input  logic [TW-1:0]         cur_time,
  input  logic                  edit_busy,
  input  logic [TW:0]           slot_data,
  input  logic                  Snooze,
  input  logic                  Stop,
  input  logic                  Mute,
  output logic [DAY_W-1:0]      slot_sel,
  output logic                  slot_rd,
  output logic                  Sound,
  output logic                  ringing,
  output logic                  snoozed,
  output logic                  alarm_evt,
  output logic [SNZ_LEFT_W-1:0] snz_left
);

  localparam int EN_BIT = slot_en_bit(TW);
  localparam int CW     = count_width(RING_MAX_MIN, SNOOZE_MIN);

  localparam logic [CW-1:0]         RING_LOAD = CW'(RING_MAX_MIN);
  localparam logic [CW-1:0]         SNZ_LOAD  = CW'(SNOOZE_MIN);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [SNZ_LEFT_W-1:0] SNZ_FULL  = SNZ_LEFT_W'(MAX_SNOOZE);
  localparam logic [DAY_W-1:0]      LAST_DAY  = DAY_W'(NSLOT - 1);

  state_t state;

  logic snooze_q;
  logic stop_q;
  logic tick_pend;

  logic snooze_edge;
  logic stop_edge;
  logic snz_take;
  logic data_cycle;
  logic hit;

  logic          ring_load;
  logic          ring_dec;
  logic [CW-1:0] ring_cnt;
  logic          ring_zero;
  logic          ring_done;

  logic          snz_load;
  logic          snz_dec;
  logic [CW-1:0] snz_cnt;
  logic          snz_zero;
  logic          snz_done;

  // Buttons act once per press, however long they are held.
  assign snooze_edge = Snooze & ~snooze_q;
  assign stop_edge   = Stop & ~stop_q;

  // A snooze only counts while presses remain; otherwise it is as if the
  // button had not been pressed at all (a coincident tick still applies).
  assign snz_take = snooze_edge & (snz_left != '0);

  // FETCH spans two cycles: the strobe cycle (slot_rd high, data not yet
  // valid) and the data cycle (slot_rd low, slot_data valid).
  assign data_cycle = (state == ST_FETCH) & ~slot_rd;

  // A day code outside the slot bank never matches.
  assign hit = slot_data[EN_BIT]
             & (slot_data[TW-1:0] == cur_time)
             & (slot_sel <= LAST_DAY);

  // "Last minute" also covers an exhausted counter so the FSM can never stall.
  assign ring_done = ring_zero | (ring_cnt == CNT_ONE);
  assign snz_done  = snz_zero  | (snz_cnt  == CNT_ONE);

  // Counter controls follow the same priority as the FSM: Stop, then an
  // accepted Snooze, then the minute tick.
  assign ring_load = (data_cycle & hit)
                   | ((state == ST_SNOOZE) & ~stop_edge & min_tick & snz_done);
  assign ring_dec  = (state == ST_RING) & ~stop_edge & ~snz_take & min_tick;
  assign snz_load  = (state == ST_RING) & ~stop_edge & snz_take;
  assign snz_dec   = (state == ST_SNOOZE) & ~stop_edge & min_tick;

  min_countdown #(
    .W (CW)
  ) u_ring_cnt (
    .clk      (Clk),
    .rst_n    (Clr),
    .load     (ring_load),
    .load_val (RING_LOAD),
    .dec      (ring_dec),
    .count    (ring_cnt),
    .zero     (ring_zero)
  );

  min_countdown #(
    .W (CW)
  ) u_snz_cnt (
    .clk      (Clk),
    .rst_n    (Clr),
    .load     (snz_load),
    .load_val (SNZ_LOAD),
    .dec      (snz_dec),
    .count    (snz_cnt),
    .zero     (snz_zero)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= ST_IDLE;
      slot_sel  <= '0;
      slot_rd   <= 1'b0;
      Sound     <= 1'b0;
      alarm_evt <= 1'b0;
      snz_left  <= SNZ_FULL;
      tick_pend <= 1'b0;
      snooze_q  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      snooze_q  <= Snooze;
      stop_q    <= Stop;
      slot_rd   <= 1'b0;
      alarm_evt <= 1'b0;
      Sound     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if ((min_tick | tick_pend) & ~edit_busy) begin
            slot_rd   <= 1'b1;
            slot_sel  <= cur_day;
            tick_pend <= 1'b0;
            state     <= ST_FETCH;
          end else if (min_tick) begin
            // Deferred by an edit; any number of ticks collapse to one fetch.
            tick_pend <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (min_tick) begin
            tick_pend <= 1'b1;
          end
          if (!slot_rd) begin
            if (hit) begin
              state     <= ST_RING;
              snz_left  <= SNZ_FULL;
              alarm_evt <= 1'b1;
              Sound     <= ~Mute;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_RING: begin
          if (stop_edge) begin
            state <= ST_IDLE;
          end else if (snz_take) begin
            state    <= ST_SNOOZE;
            snz_left <= snz_left - 1'b1;
          end else if (min_tick && ring_done) begin
            state <= ST_IDLE;
          end else begin
            Sound <= ~Mute;
          end
        end

        ST_SNOOZE: begin
          if (stop_edge) begin
            state <= ST_IDLE;
          end else if (min_tick && snz_done) begin
            state     <= ST_RING;
            alarm_evt <= 1'b1;
            Sound     <= ~Mute;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ringing = (state == ST_RING);
  assign snoozed = (state == ST_SNOOZE);

endmodule

// File: tb/tb_alarm_scheduler.sv
module tb_alarm_scheduler;

  localparam int RING_MIN = 10;
  localparam int SNZ_MIN  = 9;
  localparam int MAX_SNZ  = 3;
  localparam int P_IDLE   = 0;
  localparam int P_RING   = 1;
  localparam int P_SNZ    = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        min_tick = 1'b0;
  logic [2:0]  cur_day = 3'd0;
  logic [11:0] cur_time = 12'd0;
  logic        edit_busy = 1'b0;
  logic [12:0] slot_data = 13'd0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        mute = 1'b0;

  logic [2:0]  slot_sel;
  logic        slot_rd;
  logic        sound;
  logic        ringing;
  logic        snoozed;
  logic        alarm_evt;
  logic [1:0]  snz_left;

  logic [9:0]  dut_vec;
  assign dut_vec = {slot_rd, slot_sel, sound, ringing, snoozed, alarm_evt, snz_left};

  always #5 clk = ~clk;

  alarm_scheduler dut (
    .Clk       (clk),
    .Clr       (clr),
    .min_tick  (min_tick),
    .cur_day   (cur_day),
    .cur_time  (cur_time),
    .edit_busy (edit_busy),
    .slot_data (slot_data),
    .Snooze    (snooze),
    .Stop      (stop),
    .Mute      (mute),
    .slot_sel  (slot_sel),
    .slot_rd   (slot_rd),
    .Sound     (sound),
    .ringing   (ringing),
    .snoozed   (snoozed),
    .alarm_evt (alarm_evt),
    .snz_left  (snz_left)
  );

  // Alarm register bank with registered read.
  logic [12:0] bank [8];
  always @(posedge clk) begin
    if (slot_rd) slot_data <= bank[slot_sel];
  end

  int n_total = 0;
  int n_bad   = 0;
  int rd_cnt  = 0;
  int evt_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (minute-level rules) ----------------
  int ph;
  int fetch_age;     // -1 none, 0 strobe cycle, 1 data cycle
  int fetch_day;
  bit pend;
  int ring_left;     // minutes of ringing still allowed
  int snz_rem;       // minutes until re-ring
  int snz_avail;
  bit prev_snz, prev_stop;
  bit e_rd, e_sound, e_evt;
  int e_sel;

  task automatic model_reset();
    ph = P_IDLE; fetch_age = -1; fetch_day = 0; pend = 0;
    ring_left = 0; snz_rem = 0; snz_avail = MAX_SNZ;
    prev_snz = 0; prev_stop = 0;
    e_rd = 0; e_sound = 0; e_evt = 0; e_sel = 0;
  endtask

  task automatic model_edge();
    bit snz_ev, stop_ev;
    logic [12:0] w;
    snz_ev  = snooze && !prev_snz;
    stop_ev = stop && !prev_stop;
    prev_snz  = snooze;
    prev_stop = stop;
    e_evt = 0;
    e_rd  = 0;
    if (fetch_age == 0) begin
      fetch_age = 1;
      if (min_tick) pend = 1;
    end else if (fetch_age == 1) begin
      fetch_age = -1;
      if (min_tick) pend = 1;
      w = bank[fetch_day];
      if (w[12] && (w[11:0] == cur_time) && fetch_day < 7) begin
        ph = P_RING; ring_left = RING_MIN; snz_avail = MAX_SNZ; e_evt = 1;
      end
    end else if (ph == P_IDLE) begin
      if ((min_tick || pend) && !edit_busy) begin
        e_rd = 1; e_sel = int'(cur_day); fetch_day = int'(cur_day);
        pend = 0; fetch_age = 0;
      end else if (min_tick) begin
        pend = 1;
      end
    end else if (ph == P_RING) begin
      if (stop_ev) ph = P_IDLE;
      else if (snz_ev && snz_avail > 0) begin
        ph = P_SNZ; snz_avail--; snz_rem = SNZ_MIN;
      end else if (min_tick) begin
        ring_left--;
        if (ring_left <= 0) ph = P_IDLE;
      end
    end else begin
      if (stop_ev) ph = P_IDLE;
      else if (min_tick) begin
        snz_rem--;
        if (snz_rem <= 0) begin
          ph = P_RING; ring_left = RING_MIN; e_evt = 1;
        end
      end
    end
    e_sound = (ph == P_RING) && !mute;
  endtask

  function automatic logic [9:0] model_vec();
    logic [9:0] v;
    v = {e_rd, 3'(e_sel), e_sound, ph == P_RING, ph == P_SNZ, e_evt, 2'(snz_avail)};
    return v;
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!clr) model_reset();
    else model_edge();
    @(negedge clk);
    if (slot_rd) rd_cnt++;
    if (alarm_evt) evt_cnt++;
    check_val("outs", {22'd0, dut_vec}, {22'd0, model_vec()});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick_at(input logic [11:0] t);
    cur_time = t; min_tick = 1'b1; cyc(); min_tick = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
  endtask

  task automatic start_ring();
    cur_day = 3'd3; tick_at(12'h715); run(3);
  endtask

  initial begin
    int r0, e0;
    for (int i = 0; i < 8; i++) bank[i] = 13'd0;
    bank[0] = 13'h0123;
    bank[3] = 13'h1715;
    bank[4] = 13'h0400;
    model_reset();

    // reset state
    run(3);
    check_val("rst_vec", {22'd0, dut_vec}, 32'h003);
    clr = 1'b1;
    run(2);

    // 1: enabled slot hits, disabled slot does not
    e0 = evt_cnt; r0 = rd_cnt;
    start_ring();
    check_val("t1_rd", rd_cnt - r0, 1);
    check_val("t1_evt", evt_cnt - e0, 1);
    check_val("t1_ring", {ringing, sound}, 2'b11);
    pulse_stop();
    cur_day = 3'd4; e0 = evt_cnt;
    tick_at(12'h400); run(3);
    check_val("t1_dis", {ringing, 1'b0, evt_cnt - e0}, 0);

    // 2: auto-stop after RING_MIN ticks
    start_ring();
    for (int i = 0; i < RING_MIN - 1; i++) begin tick_at(12'h716 + 12'(i)); run(1); end
    check_val("t2_still", ringing, 1);
    tick_at(12'h730);
    check_val("t2_stop", {ringing, sound}, 2'b00);
    run(2);

    // 3: three snoozes, fourth ignored
    start_ring();
    for (int k = 0; k < MAX_SNZ; k++) begin
      pulse_snooze();
      check_val("t3_snz", {snoozed, sound}, 2'b10);
      check_val("t3_left", snz_left, 32'(2 - k));
      for (int j = 0; j < SNZ_MIN - 1; j++) begin tick_at(12'h740 + 12'(j)); run(1); end
      check_val("t3_wait", snoozed, 1);
      tick_at(12'h750);
      check_val("t3_rering", {ringing, sound}, 2'b11);
    end
    pulse_snooze();
    check_val("t3_4th", {ringing, sound, snz_left}, 4'b1100);
    pulse_stop();

    // 4: Stop beats Snooze; held Snooze acts once
    start_ring();
    snooze = 1'b1; stop = 1'b1; cyc();
    check_val("t4_both", {ringing, snoozed}, 2'b00);
    snooze = 1'b0; stop = 1'b0; run(2);
    start_ring();
    snooze = 1'b1; run(20); snooze = 1'b0; cyc();
    check_val("t4_held", {snoozed, snz_left}, 3'b110);
    pulse_stop();
    check_val("t4_idle", {ringing, snoozed}, 2'b00);

    // 5: deferred ticks collapse to one fetch; Mute gates Sound only
    cur_day = 3'd0; edit_busy = 1'b1; r0 = rd_cnt;
    tick_at(12'h100); run(2); tick_at(12'h101); run(2);
    check_val("t5_defer", rd_cnt - r0, 0);
    edit_busy = 1'b0; run(6);
    check_val("t5_one", rd_cnt - r0, 1);
    start_ring();
    mute = 1'b1; run(2);
    check_val("t5_mute", {ringing, sound}, 2'b10);
    mute = 1'b0; run(1);
    check_val("t5_unmute", {ringing, sound}, 2'b11);
    pulse_stop();

    // 6: async clear mid-SNOOZE
    start_ring();
    pulse_snooze();
    check_val("t6_pre", snoozed, 1);
    clr = 1'b0;
    #1;
    check_val("t6_async", {22'd0, dut_vec}, 32'h003);
    e0 = evt_cnt;
    run(2);
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin tick_at(12'h200 + 12'(i)); run(1); end
    check_val("t6_quiet", {ringing, 1'b0, evt_cnt - e0}, 0);

    // randomized traffic against the model
    run(5);
    for (int i = 0; i < 7; i++) begin
      if (i != 3) bank[i] = {1'($urandom_range(0, 3) != 0), 12'($urandom)};
    end
    for (int i = 0; i < 4000; i++) begin
      min_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) cur_day = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) cur_time = bank[cur_day][11:0];
      else cur_time = 12'($urandom);
      edit_busy = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) snooze = ~snooze;
      if ($urandom_range(0, 63) == 0) stop = ~stop;
      if ($urandom_range(0, 31) == 0) mute = ~mute;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
